// File: rtl/axis_skid_buf.sv
// axis_skid_buf: two-entry AXI-Stream register slice with registered tdata/tlast/tvalid and tready.
// Define AXIS_SKID_BUF_TUSER_EN to add a USER_WIDTH-wide tuser sideband carried alongside tlast.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
`ifdef AXIS_SKID_BUF_TUSER_EN
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
`endif
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);
`ifdef AXIS_SKID_BUF_TUSER_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif
    localparam int PW = DATA_WIDTH + 1 + (USER_EN ? USER_WIDTH : 0);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] in_pl, out_q, skid_q;
    logic          m_valid_q, s_ready_q;
    logic          xfer_in, xfer_out, load_in, load_skid, load_pop;

`ifdef AXIS_SKID_BUF_TUSER_EN
    assign in_pl        = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    assign m_axis_tuser = out_q[PW-1 -: USER_WIDTH];
`else
    assign in_pl        = {s_axis_tlast, s_axis_tdata};
`endif
    assign m_axis_tdata  = out_q[DATA_WIDTH-1:0];
    assign m_axis_tlast  = out_q[DATA_WIDTH];
    assign m_axis_tvalid = m_valid_q;
    assign s_axis_tready = s_ready_q;
    assign xfer_in       = s_axis_tvalid & s_ready_q;
    assign xfer_out      = m_valid_q & m_axis_tready;

    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        load_skid = 1'b0;
        load_pop  = 1'b0;
        case (state)
            EMPTY: begin
                state_nxt = xfer_in ? ONE : EMPTY;
                load_in   = xfer_in;
            end
            ONE: begin
                state_nxt = xfer_in ? (xfer_out ? ONE : FULL) : (xfer_out ? EMPTY : ONE);
                load_in   = xfer_in & xfer_out;
                load_skid = xfer_in & ~xfer_out;
            end
            FULL: begin
                state_nxt = xfer_out ? ONE : FULL;
                load_pop  = xfer_out;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Ready and valid are registered from the next state so neither port sees a combinational path.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
        end else begin
            state     <= state_nxt;
            m_valid_q <= state_nxt != EMPTY;
            s_ready_q <= state_nxt != FULL;
            if (load_in)
                out_q <= in_pl;
            else if (load_pop)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= in_pl;
        end
    end
endmodule

// File: tb/tb_axis_skid_buf.sv
// tb_axis_skid_buf: scoreboard bench for axis_skid_buf; directed and randomised traffic.
module tb_axis_skid_buf;
`ifdef AXIS_SKID_BUF_TUSER_EN
    localparam bit UEN = 1'b1;
`else
    localparam bit UEN = 1'b0;
`endif
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [15:0] s_tdata = '0, m_tdata;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic        m_tvalid, m_tlast, m_tready;
    logic [2:0]  s_tuser = '0, m_tuser_w;
    logic        rdy_dir = 1'b1, rand_rdy = 1'b0, rnd_bit = 1'b0;
    logic        stall = 1'b0;
    logic [19:0] held = '0;
    logic [19:0] exp_q[$];
    int          n_cmp = 0, n_err = 0, n_out = 0;

    assign m_tready = rand_rdy ? rnd_bit : rdy_dir;

    axis_skid_buf #(.DATA_WIDTH(16), .USER_WIDTH(3)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
`ifdef AXIS_SKID_BUF_TUSER_EN
        .s_axis_tuser(s_tuser),
        .m_axis_tuser(m_tuser_w),
`endif
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready)
    );
`ifndef AXIS_SKID_BUF_TUSER_EN
    assign m_tuser_w = '0;
`endif

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] out_word();
        return {m_tuser_w, m_tlast, m_tdata};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Holds the beat until accepted; the expected word is queued at the accepting edge.
    task automatic send(input logic [15:0] d, input logic l, input logic [2:0] u, output int waits);
        waits = 0;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_tready) begin
                exp_q.push_back({UEN ? u : 3'b0, l, d});
                break;
            end
            waits++;
            if (waits > 200) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: got no s_tready expected accept of %0h", d);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || m_tvalid) && k < 300) begin
            cyc(1);
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge aclk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Monitor: pops on every output transfer and checks stability while stalled.
    initial forever begin
        @(negedge aclk);
        if (!aresetn) stall = 1'b0;
        else begin
            if (stall) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", out_word(), held);
            end
            if (m_tvalid && m_tready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_word());
                end else chk("scoreboard", out_word(), exp_q.pop_front());
            end
            stall = m_tvalid && !m_tready;
            held = out_word();
        end
    end

    initial begin
        int w, w3, tot, base;
        #12;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        chk("tready_before_edge", s_tready, 0);
        cyc(1);
        chk("tready_after_edge", s_tready, 1);
        chk("no_beat_after_rst", m_tvalid, 0);
        rdy_dir = 1'b0;
        send(16'h0BAD, 1'b0, 3'd0, w);
        chk("mid_valid", m_tvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_m_tvalid", m_tvalid, 0);
        chk("async_rst_s_tready", s_tready, 0);
        exp_q.delete();
        cyc(2);
        aresetn = 1'b1;
        rdy_dir = 1'b1;
        cyc(3);
        chk("rst_discard", m_tvalid, 0);
        chk("rst_ready", s_tready, 1);
        tot = 0;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), i == 8, 3'd0, w);
            tot += w;
            if (i == 1) begin
                chk("lat_valid", m_tvalid, 1);
                chk("lat_data", m_tdata, 1);
            end
        end
        chk("stream_stall_cycles", tot, 0);
        drain();
        rdy_dir = 1'b0;
        send(16'hA5A5, 1'b0, 3'd0, w);
        send(16'h5A5A, 1'b0, 3'd0, w);
        chk("bp_tready_low", s_tready, 0);
        fork
            send(16'h1234, 1'b1, 3'd0, w3);
        join_none
        cyc(3);
        chk("bp_hold_data", m_tdata, 16'hA5A5);
        chk("bp_valid", m_tvalid, 1);
        chk("bp_tready", s_tready, 0);
        chk("bp_queued", exp_q.size(), 2);
        rdy_dir = 1'b1;
        wait fork;
        drain();
        cyc(2);
        send(16'h00FF, 1'b1, 3'd0, w);
        chk("single_valid", m_tvalid, 1);
        chk("single_data", m_tdata, 16'h00FF);
        chk("single_last", m_tlast, 1);
        cyc(1);
        chk("single_one_cycle", m_tvalid, 0);
        base = n_out;
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 3));
            send(16'(i * 37 + 5), (i % 7) == 6, 3'(i), w);
        end
        rand_rdy = 1'b0;
        drain();
        chk("rand_beats", n_out - base, 1000);
`ifdef AXIS_SKID_BUF_TUSER_EN
        rdy_dir = 1'b0;
        send(16'h0010, 1'b0, 3'b101, w);
        send(16'h0020, 1'b1, 3'b010, w);
        chk("user_out_reg", m_tuser_w, 3'b101);
        rdy_dir = 1'b1;
        drain();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
